// File: rtl/spu_pkg.sv
// ============================================================================
// Module  : spu_pkg
// Purpose : Shared constants, privilege encoding and FSM state type for the
//           SPU event counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spu_pkg;

    localparam int NUM_LINES = 4;

    localparam logic [1:0] PRIV_INVALID = 2'b00;
    localparam logic [1:0] PRIV_M       = 2'b01;
    localparam logic [1:0] PRIV_S       = 2'b10;
    localparam logic [1:0] PRIV_U       = 2'b11;

    typedef enum logic [0:0] {
        ST_COUNT = 1'b0,
        ST_HALT  = 1'b1
    } state_e;

    // Mask layout is [2]=M, [1]=S, [0]=U; the invalid level never passes.
    function automatic logic priv_allowed(input logic [1:0] priv,
                                          input logic [2:0] mask);
        logic ok;
        ok = 1'b0;
        case (priv)
            PRIV_M:       ok = mask[2];
            PRIV_S:       ok = mask[1];
            PRIV_U:       ok = mask[0];
            PRIV_INVALID: ok = 1'b0;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spu_line_counter.sv
// ============================================================================
// Module  : spu_line_counter
// Purpose : One wrapping event counter with clear priority and threshold hit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_line_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 clear_i,
    input  logic [CNT_WIDTH-1:0] threshold_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 hit_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] w_inc_val;

    assign w_inc_val = cnt_q + CNT_WIDTH'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = w_inc_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero threshold means "never compare".
    assign hit_o   = inc_i && !clear_i && (threshold_i != '0) && (w_inc_val == threshold_i);
    assign count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/spu_event_counter.sv
// ============================================================================
// Module  : spu_event_counter
// Purpose : Filtered per-line event counters with threshold halt/interrupt.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_event_counter
    import spu_pkg::*;
#(
    parameter int ASID_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [3:0]            e_id_i,
    input  logic [ASID_WIDTH+1:0] e_info_i,
    input  logic                  s_id_i,
    input  logic [3:0]            cfg_en_i,
    input  logic [2:0]            cfg_priv_mask_i,
    input  logic                  cfg_asid_match_i,
    input  logic [ASID_WIDTH-1:0] cfg_asid_i,
    input  logic [CNT_WIDTH-1:0]  cfg_threshold_i,
    input  logic                  clear_i,
    input  logic                  irq_ack_i,
    input  logic                  rd_req_i,
    input  logic [1:0]            rd_idx_i,
    output logic                  rd_valid_o,
    output logic [CNT_WIDTH-1:0]  rd_data_o,
    output logic                  irq_o,
    output logic [3:0]            irq_line_o
);

    logic [3:0]            e_id_q;
    logic [ASID_WIDTH+1:0] e_info_q;
    logic                  s_id_q;

    state_e                state_q, state_d;
    logic [3:0]            irq_line_q, irq_line_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [CNT_WIDTH-1:0]  rd_data_q, rd_data_d;

    logic [1:0]            w_priv;
    logic [ASID_WIDTH-1:0] w_asid;
    logic                  w_ev_ok;
    logic [3:0]            w_inc;
    logic [3:0]            w_hit;
    logic                  w_line_clr;
    logic [CNT_WIDTH-1:0]  w_count [NUM_LINES];

    assign w_priv  = e_info_q[ASID_WIDTH +: 2];
    assign w_asid  = e_info_q[ASID_WIDTH-1:0];

    // Filters use the configuration present when the registered event is evaluated.
    assign w_ev_ok = !s_id_q
                   && priv_allowed(w_priv, cfg_priv_mask_i)
                   && (!cfg_asid_match_i || (w_asid == cfg_asid_i));

    assign w_inc      = (state_q == ST_COUNT && w_ev_ok) ? (e_id_q & cfg_en_i) : 4'b0000;
    assign w_line_clr = clear_i || (state_q == ST_HALT && irq_ack_i);

    generate
        for (genvar n = 0; n < NUM_LINES; n++) begin : g_line
            spu_line_counter #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_line (
                .clk_i       (clk_i),
                .rst_ni      (rst_ni),
                .inc_i       (w_inc[n]),
                .clear_i     (w_line_clr),
                .threshold_i (cfg_threshold_i),
                .count_o     (w_count[n]),
                .hit_o       (w_hit[n])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        irq_line_d = irq_line_q;
        if (clear_i) begin
            state_d    = ST_COUNT;
            irq_line_d = 4'b0000;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (|w_hit) begin
                        state_d    = ST_HALT;
                        irq_line_d = irq_line_q | w_hit;
                    end
                end
                ST_HALT: begin
                    if (irq_ack_i) begin
                        state_d    = ST_COUNT;
                        irq_line_d = 4'b0000;
                    end
                end
                default: begin
                    state_d    = ST_COUNT;
                    irq_line_d = 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        rd_valid_d = rd_req_i;
        rd_data_d  = rd_data_q;
        if (rd_req_i) begin
            rd_data_d = w_count[rd_idx_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            e_id_q     <= '0;
            e_info_q   <= '0;
            s_id_q     <= 1'b0;
            state_q    <= ST_COUNT;
            irq_line_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            e_id_q     <= e_id_i;
            e_info_q   <= e_info_i;
            s_id_q     <= s_id_i;
            state_q    <= state_d;
            irq_line_q <= irq_line_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign irq_o      = (state_q == ST_HALT);
    assign irq_line_o = irq_line_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_spu_event_counter.sv
// ============================================================================
// Module  : tb_spu_event_counter
// Purpose : Self-checking bench: vector table, directed corners, random vs model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spu_event_counter;

    localparam int AW = 16;
    localparam int CW = 8;
    localparam int NL = 4;
    localparam int CNT_MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    e_id;
    logic [AW+1:0] e_info;
    logic          s_id;
    logic [3:0]    cfg_en;
    logic [2:0]    cfg_mask;
    logic          cfg_asid_match;
    logic [AW-1:0] cfg_asid;
    logic [CW-1:0] cfg_thr;
    logic          clear;
    logic          ack;
    logic          rd_req;
    logic [1:0]    rd_idx;
    logic          rd_valid;
    logic [CW-1:0] rd_data;
    logic          irq;
    logic [3:0]    irq_line;

    always #5 clk = ~clk;

    spu_event_counter #(
        .ASID_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .e_id_i           (e_id),
        .e_info_i         (e_info),
        .s_id_i           (s_id),
        .cfg_en_i         (cfg_en),
        .cfg_priv_mask_i  (cfg_mask),
        .cfg_asid_match_i (cfg_asid_match),
        .cfg_asid_i       (cfg_asid),
        .cfg_threshold_i  (cfg_thr),
        .clear_i          (clear),
        .irq_ack_i        (ack),
        .rd_req_i         (rd_req),
        .rd_idx_i         (rd_idx),
        .rd_valid_o       (rd_valid),
        .rd_data_o        (rd_data),
        .irq_o            (irq),
        .irq_line_o       (irq_line)
    );

    // Reference model state
    int unsigned m_cnt [NL];
    bit          m_halt;
    bit [3:0]    m_irq_line;
    bit          m_rv;
    int unsigned m_rd;
    bit [3:0]    m_pid;
    bit [1:0]    m_ppriv;
    bit [AW-1:0] m_pasid;
    bit          m_psid;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] e_id;
        logic [1:0] priv;
        logic       rd_req;
        logic [1:0] rd_idx;
        logic       exp_rv;
        logic [7:0] exp_data;
        logic       exp_irq;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit [3:0] qual;
        bit       ok;
        if (!rst_n) begin
            for (int n = 0; n < NL; n++) m_cnt[n] = 0;
            m_halt = 0; m_irq_line = 0; m_rv = 0; m_rd = 0;
            m_pid = 0; m_ppriv = 0; m_pasid = 0; m_psid = 0;
        end else begin
            ok = (m_psid == 0) && (m_ppriv != 0) && cfg_mask[3 - m_ppriv]
                 && (!cfg_asid_match || m_pasid == cfg_asid);
            qual = ok ? (m_pid & cfg_en) : 4'b0000;
            m_rv = rd_req;
            if (rd_req) m_rd = m_cnt[rd_idx];
            if (clear) begin
                for (int n = 0; n < NL; n++) m_cnt[n] = 0;
                m_halt = 0; m_irq_line = 0;
            end else if (m_halt) begin
                if (ack) begin
                    for (int n = 0; n < NL; n++) m_cnt[n] = 0;
                    m_halt = 0; m_irq_line = 0;
                end
            end else begin
                for (int n = 0; n < NL; n++) begin
                    if (qual[n]) begin
                        m_cnt[n] = (m_cnt[n] + 1) % CNT_MOD;
                        if (cfg_thr != 0 && m_cnt[n] == cfg_thr) m_irq_line[n] = 1;
                    end
                end
                if (m_irq_line != 0) m_halt = 1;
            end
            m_pid   = e_id;
            m_ppriv = e_info[AW +: 2];
            m_pasid = e_info[AW-1:0];
            m_psid  = s_id;
        end
    endtask

    task automatic compare_all();
        check("rd_valid", 32'(rd_valid), 32'(m_rv));
        check("rd_data", 32'(rd_data), m_rd);
        check("irq_o", 32'(irq), 32'(m_halt));
        check("irq_line", 32'(irq_line), 32'(m_irq_line));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic ev(input logic [3:0] id, input logic [1:0] priv, input logic [AW-1:0] asid);
        e_id   = id;
        e_info = {priv, asid};
    endtask

    task automatic do_clear();
        e_id = 4'b0000; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic read_line(input logic [1:0] idx);
        e_id = 4'b0000; rd_req = 1'b1; rd_idx = idx;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; e_id = '0; e_info = '0; s_id = 1'b0;
        cfg_en = 4'b1111; cfg_mask = 3'b111; cfg_asid_match = 1'b0; cfg_asid = '0;
        cfg_thr = '0; clear = 1'b0; ack = 1'b0; rd_req = 1'b0; rd_idx = '0;

        // Reset state
        tick();
        tick();
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;

        // Five M-mode pulses on line 0, then reads
        vt[0] = '{4'b0001, 2'b01, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0};
        vt[1] = '{4'b0001, 2'b01, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0};
        vt[2] = '{4'b0001, 2'b01, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0};
        vt[3] = '{4'b0001, 2'b01, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0};
        vt[4] = '{4'b0001, 2'b01, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0};
        vt[5] = '{4'b0000, 2'b01, 1'b1, 2'd0, 1'b1, 8'd4, 1'b0};
        vt[6] = '{4'b0000, 2'b01, 1'b1, 2'd0, 1'b1, 8'd5, 1'b0};
        vt[7] = '{4'b0000, 2'b01, 1'b1, 2'd1, 1'b1, 8'd0, 1'b0};
        vt[8] = '{4'b0000, 2'b01, 1'b1, 2'd3, 1'b1, 8'd0, 1'b0};
        vt[9] = '{4'b0000, 2'b01, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ev(vt[i].e_id, vt[i].priv, '0);
            rd_req = vt[i].rd_req;
            rd_idx = vt[i].rd_idx;
            tick();
            check($sformatf("vec%0d_rv", i), 32'(rd_valid), 32'(vt[i].exp_rv));
            check($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vt[i].exp_data));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vt[i].exp_irq));
        end
        rd_req = 1'b0;

        // Privilege filter: only M counts with mask=100
        do_clear();
        cfg_mask = 3'b100;
        for (int i = 0; i < 2; i++) begin ev(4'b0010, 2'b11, '0); tick(); end
        for (int i = 0; i < 3; i++) begin ev(4'b0010, 2'b01, '0); tick(); end
        for (int i = 0; i < 2; i++) begin ev(4'b0010, 2'b00, '0); tick(); end
        e_id = '0; tick();
        read_line(2'd1);
        check("priv_filter", 32'(rd_data), 32'd3);
        cfg_mask = 3'b111;

        // Threshold halt on lines 0 and 2 together
        do_clear();
        cfg_thr = 8'd3;
        for (int i = 0; i < 3; i++) begin ev(4'b0101, 2'b01, '0); tick(); end
        e_id = '0; tick();
        check("thr_irq", 32'(irq), 32'd1);
        check("thr_irq_line", 32'(irq_line), 32'b0101);
        for (int i = 0; i < 2; i++) begin ev(4'b0101, 2'b01, '0); tick(); end
        e_id = '0; tick();
        read_line(2'd0);
        check("halt_hold", 32'(rd_data), 32'd3);
        ack = 1'b1; tick(); ack = 1'b0;
        check("ack_irq", 32'(irq), 32'd0);
        read_line(2'd2);
        check("ack_zero", 32'(rd_data), 32'd0);
        cfg_thr = '0;

        // ASID filter
        do_clear();
        cfg_asid_match = 1'b1; cfg_asid = 16'h0012;
        for (int i = 0; i < 2; i++) begin ev(4'b1000, 2'b01, 16'h0012); tick(); end
        for (int i = 0; i < 3; i++) begin ev(4'b1000, 2'b01, 16'h0013); tick(); end
        e_id = '0; tick();
        read_line(2'd3);
        check("asid_filter", 32'(rd_data), 32'd2);
        cfg_asid_match = 1'b0;

        // Wrap at full scale
        do_clear();
        for (int i = 0; i < CNT_MOD - 1; i++) begin ev(4'b0010, 2'b01, '0); tick(); end
        e_id = '0; tick();
        read_line(2'd1);
        check("wrap_full", 32'(rd_data), 32'(CNT_MOD - 1));
        ev(4'b0010, 2'b01, '0); tick();
        e_id = '0; tick();
        read_line(2'd1);
        check("wrap_zero", 32'(rd_data), 32'd0);

        // Clear beats event and ack
        do_clear();
        for (int i = 0; i < 3; i++) begin ev(4'b0010, 2'b01, '0); tick(); end
        e_id = '0; clear = 1'b1; ack = 1'b1; tick();
        clear = 1'b0; ack = 1'b0;
        tick();
        read_line(2'd1);
        check("clear_drop", 32'(rd_data), 32'd0);

        // Back-to-back reads lag the counter by one cycle
        for (int k = 0; k < 6; k++) begin
            ev(4'b0010, 2'b01, '0); rd_req = 1'b1; rd_idx = 2'd1;
            tick();
            check($sformatf("b2b_rv%0d", k), 32'(rd_valid), 32'd1);
            check($sformatf("b2b_data%0d", k), 32'(rd_data), (k == 0) ? 32'd0 : 32'(k - 1));
        end
        rd_req = 1'b0; e_id = '0;

        // Reset while halted
        do_clear();
        cfg_thr = 8'd1;
        ev(4'b0001, 2'b01, '0); tick();
        e_id = '0; tick();
        check("pre_rst_irq", 32'(irq), 32'd1);
        rst_n = 1'b0; ev(4'b1111, 2'b01, '0); rd_req = 1'b1; tick();
        check("rst_halt_irq", 32'(irq), 32'd0);
        check("rst_halt_line", 32'(irq_line), 32'd0);
        check("rst_halt_rv", 32'(rd_valid), 32'd0);
        rst_n = 1'b1; e_id = '0; rd_req = 1'b0; cfg_thr = '0;
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) cfg_thr = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            rst_n          = ($urandom_range(0, 299) != 0);
            e_id           = 4'($urandom);
            e_info         = {2'($urandom), ($urandom_range(0, 1) == 0) ? 16'h0012 : 16'h0013};
            s_id           = ($urandom_range(0, 7) == 0);
            cfg_en         = 4'($urandom);
            cfg_mask       = 3'($urandom);
            cfg_asid_match = 1'($urandom);
            cfg_asid       = 16'h0012;
            clear          = ($urandom_range(0, 79) == 0);
            ack            = ($urandom_range(0, 7) == 0);
            rd_req         = 1'($urandom);
            rd_idx         = 2'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spu_event_counter.md
SPU_EVENT_COUNTER -- requirements
Module: spu_event_counter

Interface
REQ-001 SHALL have parameter ASID_WIDTH, default 16, meaning width of the asid field carried in e_info.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning width of each per-line counter.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low; one clock, synchronous active-low reset, sampled on rising clk_i.
REQ-005 e_id_i  in  4  per-line event pulses from the EVU (bit n = line n).
REQ-006 e_info_i  in  2+ASID_WIDTH  {priv[1:0], asid}; priv encoding 01=M, 10=S, 11=U, 00=invalid.
REQ-007 s_id_i  in  1  source id; events counted only when 0.
REQ-008 cfg_en_i  in  4  per-line count enable.
REQ-009 cfg_priv_mask_i  in  3  privilege filter, [2]=M, [1]=S, [0]=U.
REQ-010 cfg_asid_match_i  in  1  asid filter enable; cfg_asid_i  in  ASID_WIDTH  asid to match.
REQ-011 cfg_threshold_i  in  CNT_WIDTH  halt threshold; 0 disables compare.
REQ-012 clear_i  in  1  synchronous counter clear; irq_ack_i  in  1  interrupt acknowledge.
REQ-013 rd_req_i  in  1, rd_idx_i  in  2  counter read request and line index.
REQ-014 rd_valid_o  out  1, rd_data_o  out  CNT_WIDTH  read response.
REQ-015 irq_o  out  1  threshold interrupt; irq_line_o  out  4  lines that reached threshold.

Function
REQ-016 SHALL register e_id_i, e_info_i and s_id_i in one input stage; an event presented in cycle N increments its counter at the edge ending cycle N+1.
REQ-017 Registered event on line n SHALL qualify iff cfg_en_i[n], s_id==0, priv!=00, the cfg_priv_mask_i bit for that priv is set, and (cfg_asid_match_i==0 or asid==cfg_asid_i); cfg is sampled in the qualifying cycle, not at event entry.
REQ-018 FSM states COUNT and HALT; qualified events increment by exactly 1 only in COUNT.
REQ-019 Counters SHALL wrap modulo 2^CNT_WIDTH; no saturation.
REQ-020 In COUNT with threshold!=0, when a line's incremented value equals cfg_threshold_i, its irq_line_o bit SHALL set and state SHALL go to HALT at that edge; all lines hitting in the same cycle set together.
REQ-021 irq_o SHALL equal (state==HALT).
REQ-022 In HALT, counters hold and events are dropped; irq_ack_i SHALL zero all counters and irq_line_o and return to COUNT at the next edge; irq_ack_i in COUNT is ignored.
REQ-023 clear_i SHALL zero counters and irq_line_o and force COUNT, taking priority over increment and irq_ack_i; a same-cycle event is dropped.
REQ-024 rd_req_i at edge E SHALL give rd_valid_o=1 for exactly the following cycle, with rd_data_o = counter[rd_idx_i] as held before edge E's update; back-to-back reads every cycle are allowed; rd_data_o holds its value when rd_valid_o=0.

Reset
REQ-025 Under rst_ni=0 at an edge: counters, input stage, irq_line_o, rd_data_o = 0; rd_valid_o=0; irq_o=0; state COUNT; reset overrides all other inputs, including mid-HALT.

Structure
REQ-026 Shared package spu_pkg SHALL hold NUM_LINES=4, priv encoding constants and the COUNT/HALT state enum.
REQ-027 A sub-module spu_line_counter (enable, clear, threshold-hit output) SHALL be instantiated once per line.

Verification
REQ-028 rst, cfg_en=1111, mask=111, e_id=0001, priv=01 for 5 cycles -> counter0=5 two cycles after the last pulse, others 0.
REQ-029 mask=100, events with priv=11 then priv=01 -> only the priv=01 events count; priv=00 never counts.
REQ-030 threshold=3, 3 events on lines 0 and 2 simultaneously -> irq_line_o=0101, irq_o=1; further events ignored; irq_ack_i -> counters 0, irq_o=0 next cycle.
REQ-031 asid filter enabled, cfg_asid=0x12, events with asid 0x12 and 0x13 -> only 0x12 counted; counter preloaded at 0xFFFFFFFF with threshold 0 -> wraps to 0.
REQ-032 clear_i asserted together with an event and irq_ack_i -> counters 0, event dropped; rd_req_i idx=1 every cycle -> rd_valid_o continuous, data lags one cycle.
